// File: rtl/oclib_ready_valid_rr_arbiter.sv
// Round-robin arbiter merging several ready/valid streams into one registered,
// source-tagged output stream, optionally holding the grant for a whole packet.
module oclib_ready_valid_rr_arbiter #(
  parameter int Width      = 32,
  parameter int Inputs     = 4,
  parameter int IdWidth    = $clog2(Inputs),
  parameter bit LockOnLast = 1'b1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [Inputs*Width-1:0]   inData,
  input  logic [Inputs-1:0]         inLast,
  input  logic [Inputs-1:0]         inValid,
  output logic [Inputs-1:0]         inReady,
  output logic [Width-1:0]          outData,
  output logic [IdWidth-1:0]        outId,
  output logic                      outLast,
  output logic                      outValid,
  input  logic                      outReady
);

  logic [IdWidth-1:0] ptr_q, ptr_d;
  logic               locked_q, locked_d;
  logic [IdWidth-1:0] lock_id_q, lock_id_d;
  logic [Width-1:0]   out_data_q, out_data_d;
  logic [IdWidth-1:0] out_id_q, out_id_d;
  logic               out_last_q, out_last_d;
  logic               out_valid_q, out_valid_d;

  logic               can_load;
  logic               grant_valid;
  logic [IdWidth-1:0] grant_id;
  logic [IdWidth-1:0] next_ptr;
  logic [Width-1:0]   sel_data;
  logic               sel_last;
  logic               accept;

  // Position offset steps after base in round-robin order, wrapping at Inputs.
  function automatic logic [IdWidth-1:0] scan_idx(input logic [IdWidth-1:0] base,
                                                  input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= Inputs) begin
      sum = sum - Inputs;
    end else begin
      sum = sum;
    end
    return IdWidth'(sum);
  endfunction

  assign can_load = !out_valid_q || outReady;

  // Grant selection: the locked owner only, else the first valid input from ptr.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    if (locked_q) begin
      grant_valid = inValid[lock_id_q];
      grant_id    = lock_id_q;
    end else begin
      // Scan backwards so the last hit is the one closest to ptr.
      for (int k = Inputs - 1; k >= 0; k--) begin
        if (inValid[scan_idx(ptr_q, k)]) begin
          grant_valid = 1'b1;
          grant_id    = scan_idx(ptr_q, k);
        end else begin
          grant_valid = grant_valid;
        end
      end
    end
  end

  assign sel_data = inData[int'(grant_id)*Width +: Width];
  assign sel_last = inLast[grant_id];
  assign next_ptr = (grant_id == IdWidth'(Inputs - 1)) ? '0 : grant_id + IdWidth'(1);

  // Ready is one-hot on the granted input when the output register can take a beat.
  always_comb begin
    inReady = '0;
    if (reset && can_load && grant_valid) begin
      inReady = {{(Inputs-1){1'b0}}, 1'b1} << grant_id;
    end else begin
      inReady = '0;
    end
  end

  assign accept = |(inReady & inValid);

  // Next-state for arbitration pointer, packet lock and output register.
  always_comb begin
    ptr_d       = ptr_q;
    locked_d    = locked_q;
    lock_id_d   = lock_id_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      out_data_d  = sel_data;
      out_id_d    = grant_id;
      out_last_d  = sel_last;
      out_valid_d = 1'b1;
      if (!LockOnLast) begin
        locked_d = 1'b0;
        ptr_d    = next_ptr;
      end else if (sel_last) begin
        locked_d = 1'b0;
        ptr_d    = next_ptr;
      end else begin
        locked_d  = 1'b1;
        lock_id_d = grant_id;
      end
    end else if (outReady) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr_q       <= '0;
      locked_q    <= 1'b0;
      lock_id_q   <= '0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      locked_q    <= locked_d;
      lock_id_q   <= lock_id_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign outData  = out_data_q;
  assign outId    = out_id_q;
  assign outLast  = out_last_q;
  assign outValid = out_valid_q;

endmodule

// File: tb/tb_oclib_ready_valid_rr_arbiter.sv
// Self-checking bench: three arbiter instances (4 inputs unlocked, 4 inputs
// packet-locked, 3 inputs packet-locked) checked against a per-cycle model.
module tb_oclib_ready_valid_rr_arbiter;
  localparam int W = 32;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;

  logic [4*W-1:0] a_data, b_data;
  logic [3*W-1:0] c_data;
  logic [3:0]     a_last, a_valid, a_ready, b_last, b_valid, b_ready;
  logic [2:0]     c_last, c_valid, c_ready;
  logic [W-1:0]   a_odata, b_odata, c_odata;
  logic [1:0]     a_oid, b_oid, c_oid;
  logic           a_olast, a_ovalid, a_oready;
  logic           b_olast, b_ovalid, b_oready;
  logic           c_olast, c_ovalid, c_oready;

  oclib_ready_valid_rr_arbiter #(.Width(W), .Inputs(4), .LockOnLast(1'b0)) u_a (
    .clock(clock), .reset(reset), .inData(a_data), .inLast(a_last), .inValid(a_valid),
    .inReady(a_ready), .outData(a_odata), .outId(a_oid), .outLast(a_olast),
    .outValid(a_ovalid), .outReady(a_oready));

  oclib_ready_valid_rr_arbiter #(.Width(W), .Inputs(4), .LockOnLast(1'b1)) u_b (
    .clock(clock), .reset(reset), .inData(b_data), .inLast(b_last), .inValid(b_valid),
    .inReady(b_ready), .outData(b_odata), .outId(b_oid), .outLast(b_olast),
    .outValid(b_ovalid), .outReady(b_oready));

  oclib_ready_valid_rr_arbiter #(.Width(W), .Inputs(3), .LockOnLast(1'b1)) u_c (
    .clock(clock), .reset(reset), .inData(c_data), .inLast(c_last), .inValid(c_valid),
    .inReady(c_ready), .outData(c_odata), .outId(c_oid), .outLast(c_olast),
    .outValid(c_ovalid), .outReady(c_oready));

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Model configuration and state per instance (0=a, 1=b, 2=c).
  int          n_cfg   [3] = '{4, 4, 3};
  bit          lol_cfg [3] = '{1'b0, 1'b1, 1'b1};
  int          m_ptr   [3] = '{0, 0, 0};
  int          m_lockid[3] = '{0, 0, 0};
  bit          m_locked[3] = '{1'b0, 1'b0, 1'b0};
  bit          m_ov    [3] = '{1'b0, 1'b0, 1'b0};
  bit          m_ol    [3] = '{1'b0, 1'b0, 1'b0};
  int          m_oid   [3] = '{0, 0, 0};
  logic [31:0] m_od    [3] = '{32'd0, 32'd0, 32'd0};

  // Log of beats leaving each DUT (outValid && outReady).
  int          log_inst[$];
  int          log_id[$];
  logic [31:0] log_dat[$];
  int          log_cyc[$];

  task automatic chk(input int k, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (inst %0d) at %0t: got %0h, expected %0h", name, k, $time, act, exp);
    end
  endtask

  function automatic int model_grant(input int n, input int ptr, input bit locked,
                                     input int lockid, input logic [15:0] v);
    if (locked) return v[lockid] ? lockid : -1;
    for (int s = 0; s < n; s++) begin
      if (v[(ptr + s) % n]) return (ptr + s) % n;
    end
    return -1;
  endfunction

  always @(posedge clock) cyc++;

  // Compare every instance against the model, then advance the model.
  always @(negedge clock) begin
    logic [15:0] v, l, ar, er;
    logic [W-1:0] d [4];
    logic ordy, aov, aol;
    logic [W-1:0] aod;
    int aid, g;
    bit acc;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) d[i] = '0;
      case (k)
        0: begin
          v = {12'd0, a_valid}; l = {12'd0, a_last}; ar = {12'd0, a_ready};
          ordy = a_oready; aov = a_ovalid; aol = a_olast; aod = a_odata; aid = int'(a_oid);
          for (int i = 0; i < 4; i++) d[i] = a_data[i*W +: W];
        end
        1: begin
          v = {12'd0, b_valid}; l = {12'd0, b_last}; ar = {12'd0, b_ready};
          ordy = b_oready; aov = b_ovalid; aol = b_olast; aod = b_odata; aid = int'(b_oid);
          for (int i = 0; i < 4; i++) d[i] = b_data[i*W +: W];
        end
        default: begin
          v = {13'd0, c_valid}; l = {13'd0, c_last}; ar = {13'd0, c_ready};
          ordy = c_oready; aov = c_ovalid; aol = c_olast; aod = c_odata; aid = int'(c_oid);
          for (int i = 0; i < 3; i++) d[i] = c_data[i*W +: W];
        end
      endcase
      g = model_grant(n_cfg[k], m_ptr[k], m_locked[k], m_lockid[k], v);
      er = '0;
      acc = 1'b0;
      if (reset && (!m_ov[k] || ordy) && g >= 0) begin
        er[g] = 1'b1;
        acc = 1'b1;
      end
      chk(k, "inReady", 32'(ar), 32'(er));
      chk(k, "outValid", 32'(aov), 32'(m_ov[k]));
      chk(k, "outData", aod, m_od[k]);
      chk(k, "outId", 32'(aid), 32'(m_oid[k]));
      chk(k, "outLast", 32'(aol), 32'(m_ol[k]));
      if (aov === 1'b1 && ordy === 1'b1) begin
        log_inst.push_back(k); log_id.push_back(aid); log_dat.push_back(aod); log_cyc.push_back(cyc);
      end
      if (!reset) begin
        m_ptr[k] = 0; m_locked[k] = 1'b0; m_lockid[k] = 0;
        m_ov[k] = 1'b0; m_ol[k] = 1'b0; m_oid[k] = 0; m_od[k] = '0;
      end else if (acc) begin
        m_od[k] = d[g]; m_oid[k] = g; m_ol[k] = l[g]; m_ov[k] = 1'b1;
        if (!lol_cfg[k] || l[g]) begin
          m_locked[k] = 1'b0;
          m_ptr[k] = (g + 1) % n_cfg[k];
        end else begin
          m_locked[k] = 1'b1;
          m_lockid[k] = g;
        end
      end else if (ordy) begin
        m_ov[k] = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_log();
    log_inst.delete(); log_id.delete(); log_dat.delete(); log_cyc.delete();
  endtask

  task automatic expect_log(input int idx, input int k, input int id, input logic [31:0] dat);
    if (idx < log_id.size()) begin
      chk(k, "log_inst", 32'(log_inst[idx]), 32'(k));
      chk(k, "log_id", 32'(log_id[idx]), 32'(id));
      chk(k, "log_data", log_dat[idx], dat);
    end else begin
      chk(k, "log_missing", 32'(log_id.size()), 32'(idx + 1));
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    a_valid = '0; b_valid = '0; c_valid = '0;
    a_last = '0; b_last = '0; c_last = '0;
    a_oready = 1'b1; b_oready = 1'b1; c_oready = 1'b1;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    // Reset held with every input valid.
    reset = 1'b0;
    for (int i = 0; i < 4; i++) a_data[i*W +: W] = 32'h10 + 32'(i);
    b_data = '0; c_data = '0;
    a_last = 4'hF; b_last = 4'hF; c_last = 3'h7;
    a_valid = 4'hF; b_valid = 4'hF; c_valid = 3'h7;
    a_oready = 1'b1; b_oready = 1'b1; c_oready = 1'b1;
    repeat (3) begin
      tick();
      chk(0, "rst_inReady", 32'(a_ready), 32'd0);
      chk(0, "rst_outValid", 32'(a_ovalid), 32'd0);
      chk(0, "rst_outData", a_odata, 32'd0);
      chk(0, "rst_outId", 32'(a_oid), 32'd0);
    end
    reset = 1'b1;
    #1;
    chk(0, "first_grant", 32'(a_ready), 32'h1);
    tick();
    chk(0, "first_out_id", 32'(a_oid), 32'd0);
    chk(0, "first_out_data", a_odata, 32'h10);

    // Rotation with every input valid and single-beat packets.
    do_reset();
    a_last = 4'hF; a_valid = 4'hF;
    clear_log();
    repeat (6) tick();
    a_valid = '0;
    tick(); tick();
    chk(0, "rot_count", 32'(log_id.size()), 32'd6);
    begin
      int exp_ids [6] = '{0, 1, 2, 3, 0, 1};
      for (int i = 0; i < 6; i++) begin
        expect_log(i, 0, exp_ids[i], 32'h10 + 32'(exp_ids[i]));
        if (i < log_cyc.size()) chk(0, "rot_gap", 32'(log_cyc[i] - log_cyc[0]), 32'(i));
      end
    end

    // Backpressure: one beat held while outReady is low.
    do_reset();
    a_last = 4'hF; a_valid = 4'hF; a_oready = 1'b0;
    clear_log();
    tick();
    repeat (5) begin
      tick();
      chk(0, "bp_outValid", 32'(a_ovalid), 32'd1);
      chk(0, "bp_outData", a_odata, 32'h10);
      chk(0, "bp_outId", 32'(a_oid), 32'd0);
      chk(0, "bp_outLast", 32'(a_olast), 32'd1);
      chk(0, "bp_inReady", 32'(a_ready), 32'd0);
    end
    a_oready = 1'b1;
    #1;
    chk(0, "bp_release_ready", 32'(a_ready), 32'h2);
    tick();
    chk(0, "bp_reload_valid", 32'(a_ovalid), 32'd1);
    chk(0, "bp_reload_id", 32'(a_oid), 32'd1);
    chk(0, "bp_reload_data", a_odata, 32'h11);
    a_valid = '0;
    tick(); tick();
    expect_log(0, 0, 0, 32'h10);
    expect_log(1, 0, 1, 32'h11);

    // Packet lock: input 2 sends three beats while input 1 waits.
    do_reset();
    clear_log();
    b_data[2*W +: W] = 32'h20; b_last = 4'b0000; b_valid = 4'b0100;
    tick();
    b_data[2*W +: W] = 32'h21; b_data[1*W +: W] = 32'h31; b_last = 4'b0010; b_valid = 4'b0110;
    #1;
    chk(1, "lock_beat2_ready", 32'(b_ready), 32'h4);
    tick();
    b_data[2*W +: W] = 32'h22; b_last = 4'b0110;
    #1;
    chk(1, "lock_beat3_ready", 32'(b_ready), 32'h4);
    tick();
    b_valid = 4'b0010;
    #1;
    chk(1, "lock_after_ready", 32'(b_ready), 32'h2);
    tick();
    b_valid = '0;
    tick(); tick();
    chk(1, "lock_count", 32'(log_id.size()), 32'd4);
    expect_log(0, 1, 2, 32'h20);
    expect_log(1, 1, 2, 32'h21);
    expect_log(2, 1, 2, 32'h22);
    expect_log(3, 1, 1, 32'h31);

    // Wrap and sparse requests on three inputs.
    do_reset();
    clear_log();
    for (int i = 0; i < 3; i++) c_data[i*W +: W] = 32'hC0 + 32'(i);
    c_last = 3'b111; c_valid = 3'b010;
    #1;
    chk(2, "wrap_first_ready", 32'(c_ready), 32'h2);
    tick();
    chk(2, "wrap_sparse_ready", 32'(c_ready), 32'h2);
    tick();
    c_valid = 3'b101;
    #1;
    chk(2, "wrap_ptr2_ready", 32'(c_ready), 32'h4);
    tick();
    chk(2, "wrap_to0_ready", 32'(c_ready), 32'h1);
    tick();
    c_valid = '0;
    tick(); tick();
    expect_log(0, 2, 1, 32'hC1);
    expect_log(1, 2, 1, 32'hC1);
    expect_log(2, 2, 2, 32'hC2);
    expect_log(3, 2, 0, 32'hC0);

    // Reset in the middle of a locked packet from input 3.
    do_reset();
    b_data[3*W +: W] = 32'h40; b_last = 4'b0000; b_valid = 4'b1000;
    tick();
    b_data[3*W +: W] = 32'h41; b_data[0*W +: W] = 32'h50; b_last = 4'b0001; b_valid = 4'b1001;
    #1;
    chk(1, "midrst_locked_ready", 32'(b_ready), 32'h8);
    reset = 1'b0;
    #1;
    chk(1, "midrst_ready_low", 32'(b_ready), 32'h0);
    tick();
    chk(1, "midrst_outValid", 32'(b_ovalid), 32'd0);
    chk(1, "midrst_outData", b_odata, 32'd0);
    reset = 1'b1;
    #1;
    chk(1, "midrst_regrant", 32'(b_ready), 32'h1);
    tick();
    chk(1, "midrst_out_id", 32'(b_oid), 32'd0);
    chk(1, "midrst_out_data", b_odata, 32'h50);
    b_valid = '0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/oclib_ready_valid_rr_arbiter.md
# oclib_ready_valid_rr_arbiter

Round-robin arbiter that shares one ready/valid datapath between `Inputs` requesting streams. It merges them into a single registered output stream tagged with the source index. It sits in front of an `oclib_ready_valid_pipeline` or any single-consumer ready/valid sink. It optionally holds the grant for a whole multi-beat packet.

## Interface
- `Width`, 32, data bits per beat
- `Inputs`, 4, number of requesting streams (2..16)
- `IdWidth`, `$clog2(Inputs)`, width of source tag
- `LockOnLast`, 1, 1 = grant held until a beat with `inLast` is accepted; 0 = re-arbitrate every beat

Ports:
- `clock`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-low reset
- `inData`  in  `Inputs*Width`  packed beats; input i at `[i*Width +: Width]`
- `inLast`  in  `Inputs`  end-of-packet marker per input
- `inValid`  in  `Inputs`  beat valid per input
- `inReady`  out  `Inputs`  beat accepted per input (one-hot or zero)
- `outData`  out  `Width`  registered granted beat
- `outId`  out  `IdWidth`  index of the input that supplied `outData`
- `outLast`  out  1  registered copy of the granted `inLast`
- `outValid`  out  1  output beat valid
- `outReady`  in  1  downstream accepts beat

## Operation
- State:
  - `ptr` (IdWidth), the highest-priority input
  - `locked` (1)
  - `lockId` (IdWidth)
  - output register {`outData`, `outId`, `outLast`, `outValid`}
- `canLoad = !outValid || outReady`.
- Grant selection (combinational):
  - When `locked`: grant = `lockId` if `inValid[lockId]`, else no grant. Other inputs are never granted while locked.
  - When not locked: grant = first i with `inValid[i]` scanning `ptr, ptr+1, ..., Inputs-1, 0, ..., ptr-1`. No valid input means no grant.
- `inReady[i] = reset && canLoad && grant==i`. At most one bit is set.
- Accept = `inValid[g] && inReady[g]`. On accept:
  - The output register loads `inData[g]`, `g`, `inLast[g]`.
  - `outValid` is set to 1.
- `outValid` clears when `outReady && outValid` with no accept in the same cycle.
- Lock (LockOnLast=1):
  - Accept with `inLast=0` sets `locked=1`, `lockId=g`.
  - Accept with `inLast=1` clears `locked`.
- LockOnLast=0: `locked` stays 0.
- Pointer update:
  - On accept with `inLast=1`, or on any accept when LockOnLast=0: `ptr = (g+1) mod Inputs`. Wrap from `Inputs-1` goes to 0, including non-power-of-2 `Inputs`.
  - Otherwise `ptr` holds.
- Output stability: while `outValid && !outReady`, the outputs `outData`, `outId`, `outLast` hold and `outValid` stays 1.
- Reset values (reset=0 at a clock edge):
  - `outValid=0`, `outData=0`, `outId=0`, `outLast=0`
  - `ptr=0`, `locked=0`, `lockId=0`
  - `inReady` forced to all 0 while reset is low
- Reset mid-packet discards the lock and any held output beat. No partial-packet recovery.

## Timing
- Latency: a beat accepted at edge N appears on `outValid`/`outData` after edge N, so it is visible in cycle N+1.
- Throughput: 1 beat/cycle sustained with `outReady=1`, including back-to-back beats from different inputs. There are no bubbles on a grant switch.
- Combinational paths:
  - `outReady` → `inReady`
  - `inValid` (all inputs) → `inReady`
- Valid must not depend on ready. `inValid` may never be a function of `inReady`.
- Fairness: with all inputs continuously valid and LockOnLast=0, grants rotate 0,1,...,Inputs-1,0. Each input waits at most `Inputs-1` packets.
- Simultaneous output drain and new accept in the same cycle gives a seamless reload with `outValid` held at 1.
- A locked input that deasserts `inValid` mid-packet stalls the arbiter (no grant). Other valid inputs remain blocked until the packet's last beat.

## Test plan
- Reset: hold reset=0 for 3 cycles with all inValid=1. Required: inReady=0, outValid=0, outData=0, outId=0. Release; the first grant goes to input 0.
- Rotation: Inputs=4, LockOnLast=0, all inputs valid, inLast=1, data=0x10+i, outReady=1. Required: outId sequence 0,1,2,3,0,1 on consecutive cycles, outData matching, no idle cycles.
- Packet lock: LockOnLast=1. Input 2 sends 3 beats (last on 3rd); input 1 is valid throughout. Required: outId=2,2,2 then 1; inReady[1]=0 until input 2's last beat is accepted.
- Backpressure: outReady=0 for 5 cycles after one beat is accepted. Required: outValid=1 and outData/outId/outLast constant; all inReady=0. On outReady=1, the next beat loads the same cycle.
- Wrap and sparse: Inputs=3, ptr=2, only input 1 valid. Required: grant to 1, next ptr=2. Then inputs 0 and 2 valid: grant to 2, then to 0.
- Reset mid-packet: LockOnLast=1, assert reset after beat 1 of 3 from input 3. Required: locked cleared, outValid=0; after release, input 0 is granted if valid.
